// File: rtl/reg_scoreboard_if.sv
// Issue/writeback bundle between the ID/WB stages and the register scoreboard.
// The slave side is the scoreboard; the master side is the pipeline driving it.
interface reg_scoreboard_if #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned CNT_W    = 2
);
    logic                   issue_valid;
    logic                   issue_wb_en;
    logic [REG_W-1:0]       issue_dest;
    logic [REG_W-1:0]       src1;
    logic [REG_W-1:0]       src2;
    logic                   has_two_src;
    logic                   Ignore_Hazard;
    logic                   flush;
    logic                   wb_valid;
    logic [REG_W-1:0]       wb_dest;
    logic                   stall;
    logic                   issue_accept;
    logic [NUM_REGS-1:0]    busy_mask;
    logic [REG_W+CNT_W-1:0] pending_total;
    logic                   sb_err;

    modport master (
        output issue_valid, issue_wb_en, issue_dest, src1, src2, has_two_src,
               Ignore_Hazard, flush, wb_valid, wb_dest,
        input  stall, issue_accept, busy_mask, pending_total, sb_err
    );

    modport slave (
        input  issue_valid, issue_wb_en, issue_dest, src1, src2, has_two_src,
               Ignore_Hazard, flush, wb_valid, wb_dest,
        output stall, issue_accept, busy_mask, pending_total, sb_err
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write counters: incremented on issue, retired on writeback,
// used to stall ID-stage readers of registers that still have a write outstanding.
module reg_scoreboard #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned REG_W    = 4,
    parameter int unsigned CNT_W    = 2
) (
    input  logic            clk,
    input  logic            rst,
    reg_scoreboard_if.slave sb
);
    localparam int unsigned TOT_W = REG_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_q [NUM_REGS];
    logic [CNT_W-1:0]    cnt_d [NUM_REGS];
    logic [NUM_REGS-1:0] inc_vec;
    logic [NUM_REGS-1:0] dec_vec;
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [TOT_W-1:0]    total_q;
    logic [TOT_W-1:0]    total_d;
    logic                err_q;
    logic                err_d;

    logic src1_busy_c;
    logic src2_busy_c;
    logic hazard_c;
    logic full_c;
    logic stall_c;
    logic accept_c;

    // A lone pending write is released by a same-cycle writeback (regfile writes on negedge).
    function automatic logic eff_busy(input logic [CNT_W-1:0] cnt, input logic wb_here);
        return (cnt > CNT_W'(1)) || ((cnt == CNT_W'(1)) && !wb_here);
    endfunction

    // Hazard, full and issue decisions for the instruction sitting in ID.
    always_comb begin
        src1_busy_c = eff_busy(cnt_q[sb.src1], sb.wb_valid && (sb.wb_dest == sb.src1));
        src2_busy_c = eff_busy(cnt_q[sb.src2], sb.wb_valid && (sb.wb_dest == sb.src2));
        hazard_c    = src1_busy_c || (sb.has_two_src && src2_busy_c);
        full_c      = sb.issue_wb_en && (cnt_q[sb.issue_dest] == CNT_MAX)
                      && !(sb.wb_valid && (sb.wb_dest == sb.issue_dest));
        // Ignore_Hazard masks source hazards only; a saturated counter always holds issue.
        stall_c     = sb.issue_valid && !sb.flush
                      && ((!sb.Ignore_Hazard && hazard_c) || full_c);
        accept_c    = sb.issue_valid && !sb.flush && !stall_c;
    end

    // Per-register increment/decrement requests.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            inc_vec[r] = accept_c && sb.issue_wb_en && (sb.issue_dest == REG_W'(r));
            dec_vec[r] = sb.wb_valid && (sb.wb_dest == REG_W'(r)) && (cnt_q[r] != '0);
        end
    end

    // Next-state counters plus the summaries derived from them.
    always_comb begin
        busy_d  = '0;
        total_d = '0;
        err_d   = err_q;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_vec[r] && !dec_vec[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_vec[r] && !inc_vec[r]) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
            busy_d[r] = (cnt_d[r] != '0);
            total_d   = total_d + TOT_W'(cnt_d[r]);
        end
        if (sb.wb_valid && (cnt_q[sb.wb_dest] == '0)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            busy_q  <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            busy_q  <= busy_d;
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    assign sb.stall         = stall_c;
    assign sb.issue_accept  = accept_c;
    assign sb.busy_mask     = busy_q;
    assign sb.pending_total = total_q;
    assign sb.sb_err        = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed scenarios and random traffic checked against
// an array-of-counts reference model of the write tracking rules.
module tb_reg_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b0;

    reg_scoreboard_if #(.NUM_REGS(16), .REG_W(4), .CNT_W(2)) bus ();

    reg_scoreboard #(.NUM_REGS(16), .REG_W(4), .CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .sb  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic       wen;
        logic [3:0] dest;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       two;
        logic       ign;
        logic       fl;
        logic       wv;
        logic [3:0] wd;
    } stim_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: number of outstanding writes per register and sticky error.
    int cnt [16];
    bit m_err;

    function automatic stim_t mk(input logic iv, input logic wen, input int dest,
                                 input int s1, input int s2, input logic two,
                                 input logic ign, input logic fl, input logic wv,
                                 input int wd);
        stim_t v;
        v.iv = iv; v.wen = wen; v.dest = 4'(dest); v.s1 = 4'(s1); v.s2 = 4'(s2);
        v.two = two; v.ign = ign; v.fl = fl; v.wv = wv; v.wd = 4'(wd);
        return v;
    endfunction

    function automatic bit m_reads_stale(input int x, input stim_t v);
        int left;
        left = cnt[x];
        if (v.wv && int'(v.wd) == x && left > 0) left = left - 1;
        return left > 0;
    endfunction

    function automatic bit m_stall(input stim_t v);
        bit hz, full;
        if (!v.iv || v.fl) return 1'b0;
        hz   = m_reads_stale(int'(v.s1), v) || (v.two && m_reads_stale(int'(v.s2), v));
        full = v.wen && cnt[int'(v.dest)] == 3 && !(v.wv && v.wd == v.dest);
        return (!v.ign && hz) || full;
    endfunction

    function automatic bit m_accept(input stim_t v);
        return v.iv && !v.fl && !m_stall(v);
    endfunction

    task automatic m_commit(input stim_t v);
        bit acc, retire;
        acc    = m_accept(v);
        retire = v.wv && cnt[int'(v.wd)] > 0;
        if (v.wv && !retire) m_err = 1'b1;
        if (acc && v.wen) cnt[int'(v.dest)] = cnt[int'(v.dest)] + 1;
        if (retire) cnt[int'(v.wd)] = cnt[int'(v.wd)] - 1;
    endtask

    function automatic logic [15:0] m_mask();
        logic [15:0] m;
        m = '0;
        for (int r = 0; r < 16; r++) if (cnt[r] != 0) m[r] = 1'b1;
        return m;
    endfunction

    function automatic logic [5:0] m_total();
        int s;
        s = 0;
        for (int r = 0; r < 16; r++) s += cnt[r];
        return 6'(s);
    endfunction

    task automatic apply(input stim_t v);
        bus.issue_valid   = v.iv;
        bus.issue_wb_en   = v.wen;
        bus.issue_dest    = v.dest;
        bus.src1          = v.s1;
        bus.src2          = v.s2;
        bus.has_two_src   = v.two;
        bus.Ignore_Hazard = v.ign;
        bus.flush         = v.fl;
        bus.wb_valid      = v.wv;
        bus.wb_dest       = v.wd;
    endtask

    task automatic m_clear();
        for (int r = 0; r < 16; r++) cnt[r] = 0;
        m_err = 1'b0;
    endtask

    // Pulse reset for one cycle with idle inputs; returns just after a rising edge.
    task automatic do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;
        m_clear();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        stim_t v;
        rst = 1'b0;
        m_clear();
        v = mk(1, 1, 3, 3, 3, 1, 0, 0, 0, 0);
        apply(v);
        @(posedge clk); #1;
        n_checks++;
        if (bus.busy_mask !== 16'h0000) begin
            n_fail++; $display("FAIL reset busy_mask got %h exp 0000", bus.busy_mask);
        end
        n_checks++;
        if (bus.pending_total !== 6'd0) begin
            n_fail++; $display("FAIL reset pending_total got %0d exp 0", bus.pending_total);
        end
        n_checks++;
        if (bus.sb_err !== 1'b0) begin
            n_fail++; $display("FAIL reset sb_err got %b exp 0", bus.sb_err);
        end
        n_checks++;
        if (bus.stall !== 1'b0 || bus.issue_accept !== 1'b1) begin
            n_fail++; $display("FAIL reset stall/accept got %b/%b exp 0/1", bus.stall, bus.issue_accept);
        end
        v.fl = 1'b1;
        apply(v); #1;
        n_checks++;
        if (bus.issue_accept !== 1'b0) begin
            n_fail++; $display("FAIL reset flush accept got %b exp 0", bus.issue_accept);
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_raw_hazard();
        stim_t q[$];
        do_reset();
        q.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0));  // issue write R3
        q.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0, 0, 0));  // reader of R3 stalls
        q.push_back(mk(1, 0, 0, 3, 0, 0, 0, 0, 1, 3));  // same-cycle wb releases it
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]); #1;
            n_checks++;
            if (bus.stall !== m_stall(q[i])) begin
                n_fail++; $display("FAIL raw_hazard stall step %0d got %b exp %b", i, bus.stall, m_stall(q[i]));
            end
            n_checks++;
            if (bus.issue_accept !== m_accept(q[i])) begin
                n_fail++; $display("FAIL raw_hazard accept step %0d got %b exp %b", i, bus.issue_accept, m_accept(q[i]));
            end
            m_commit(q[i]);
            @(posedge clk); #1;
            n_checks++;
            if (bus.busy_mask !== m_mask() || bus.pending_total !== m_total() || bus.sb_err !== m_err) begin
                n_fail++; $display("FAIL raw_hazard state step %0d got %h/%0d/%b exp %h/%0d/%b", i,
                    bus.busy_mask, bus.pending_total, bus.sb_err, m_mask(), m_total(), m_err);
            end
        end
        n_checks++;
        if (bus.busy_mask !== 16'h0000) begin
            n_fail++; $display("FAIL raw_hazard final busy_mask got %h exp 0000", bus.busy_mask);
        end
    endtask

    task automatic test_full();
        stim_t q[$];
        do_reset();
        repeat (3) q.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0));  // fourth write: full
        q.push_back(mk(1, 1, 5, 0, 0, 0, 1, 0, 0, 0));  // Ignore_Hazard does not bypass full
        q.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 1, 5));  // wb frees a slot, count stays 3
        repeat (3) q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5));
        foreach (q[i]) begin
            apply(q[i]); #1;
            n_checks++;
            if (bus.stall !== m_stall(q[i])) begin
                n_fail++; $display("FAIL full stall step %0d got %b exp %b", i, bus.stall, m_stall(q[i]));
            end
            n_checks++;
            if (bus.issue_accept !== m_accept(q[i])) begin
                n_fail++; $display("FAIL full accept step %0d got %b exp %b", i, bus.issue_accept, m_accept(q[i]));
            end
            m_commit(q[i]);
            @(posedge clk); #1;
            n_checks++;
            if (bus.busy_mask !== m_mask() || bus.pending_total !== m_total() || bus.sb_err !== m_err) begin
                n_fail++; $display("FAIL full state step %0d got %h/%0d/%b exp %h/%0d/%b", i,
                    bus.busy_mask, bus.pending_total, bus.sb_err, m_mask(), m_total(), m_err);
            end
        end
    endtask

    task automatic test_two_src();
        stim_t q[$];
        do_reset();
        q.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 0, 0, 1, 7, 0, 0, 0, 0, 0));  // src2 not real: no stall
        q.push_back(mk(1, 0, 0, 1, 7, 1, 0, 0, 0, 0));  // src2 real: stall
        q.push_back(mk(1, 0, 0, 1, 7, 1, 1, 0, 0, 0));  // Ignore_Hazard suppresses
        q.push_back(mk(1, 0, 0, 7, 1, 0, 0, 0, 0, 0));  // src1 busy
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7));
        foreach (q[i]) begin
            apply(q[i]); #1;
            n_checks++;
            if (bus.stall !== m_stall(q[i])) begin
                n_fail++; $display("FAIL two_src stall step %0d got %b exp %b", i, bus.stall, m_stall(q[i]));
            end
            n_checks++;
            if (bus.issue_accept !== m_accept(q[i])) begin
                n_fail++; $display("FAIL two_src accept step %0d got %b exp %b", i, bus.issue_accept, m_accept(q[i]));
            end
            m_commit(q[i]);
            @(posedge clk); #1;
            n_checks++;
            if (bus.busy_mask !== m_mask() || bus.pending_total !== m_total() || bus.sb_err !== m_err) begin
                n_fail++; $display("FAIL two_src state step %0d got %h/%0d/%b exp %h/%0d/%b", i,
                    bus.busy_mask, bus.pending_total, bus.sb_err, m_mask(), m_total(), m_err);
            end
        end
    endtask

    task automatic test_flush();
        stim_t q[$];
        do_reset();
        q.push_back(mk(1, 1, 2, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 1, 4, 2, 0, 0, 0, 1, 0, 0));  // hazard but flushed
        q.push_back(mk(1, 1, 4, 0, 0, 0, 0, 1, 0, 0));  // clean but flushed: no increment
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2));
        foreach (q[i]) begin
            apply(q[i]); #1;
            n_checks++;
            if (bus.stall !== m_stall(q[i])) begin
                n_fail++; $display("FAIL flush stall step %0d got %b exp %b", i, bus.stall, m_stall(q[i]));
            end
            n_checks++;
            if (bus.issue_accept !== m_accept(q[i])) begin
                n_fail++; $display("FAIL flush accept step %0d got %b exp %b", i, bus.issue_accept, m_accept(q[i]));
            end
            m_commit(q[i]);
            @(posedge clk); #1;
            n_checks++;
            if (bus.busy_mask !== m_mask() || bus.pending_total !== m_total() || bus.sb_err !== m_err) begin
                n_fail++; $display("FAIL flush state step %0d got %h/%0d/%b exp %h/%0d/%b", i,
                    bus.busy_mask, bus.pending_total, bus.sb_err, m_mask(), m_total(), m_err);
            end
        end
    endtask

    task automatic test_underflow_reset();
        stim_t q[$];
        stim_t v;
        do_reset();
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 9));  // wb with nothing pending
        q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        q.push_back(mk(1, 1, 6, 0, 0, 0, 0, 0, 0, 0));
        foreach (q[i]) begin
            apply(q[i]); #1;
            m_commit(q[i]);
            @(posedge clk); #1;
            n_checks++;
            if (bus.busy_mask !== m_mask() || bus.pending_total !== m_total() || bus.sb_err !== m_err) begin
                n_fail++; $display("FAIL underflow state step %0d got %h/%0d/%b exp %h/%0d/%b", i,
                    bus.busy_mask, bus.pending_total, bus.sb_err, m_mask(), m_total(), m_err);
            end
        end
        // Asynchronous reset in the middle of a cycle.
        v = mk(1, 0, 0, 1, 6, 1, 0, 0, 0, 0);
        apply(v);
        rst = 1'b0;
        m_clear();
        #1;
        n_checks++;
        if (bus.sb_err !== 1'b0 || bus.busy_mask !== 16'h0000 || bus.pending_total !== 6'd0) begin
            n_fail++; $display("FAIL async_reset state got %b/%h/%0d exp 0/0000/0",
                bus.sb_err, bus.busy_mask, bus.pending_total);
        end
        n_checks++;
        if (bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL async_reset stall got %b exp 0", bus.stall);
        end
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.stall !== m_stall(v) || bus.issue_accept !== m_accept(v)) begin
            n_fail++; $display("FAIL post_reset stall/accept got %b/%b exp %b/%b",
                bus.stall, bus.issue_accept, m_stall(v), m_accept(v));
        end
        m_commit(v);
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        stim_t v;
        do_reset();
        for (int i = 0; i < 500; i++) begin
            v.iv   = 1'($urandom_range(0, 3) != 0);
            v.wen  = 1'($urandom_range(0, 3) != 0);
            v.dest = 4'($urandom_range(0, 3));
            v.s1   = 4'($urandom_range(0, 4));
            v.s2   = 4'($urandom_range(0, 4));
            v.two  = 1'($urandom_range(0, 1));
            v.ign  = 1'($urandom_range(0, 7) == 0);
            v.fl   = 1'($urandom_range(0, 7) == 0);
            v.wv   = 1'b0;
            v.wd   = 4'd0;
            if ($urandom_range(0, 2) != 0) begin
                for (int t = 0; t < 6; t++) begin
                    int r;
                    r = int'($urandom_range(0, 3));
                    if (!v.wv && cnt[r] > 0) begin
                        v.wv = 1'b1;
                        v.wd = 4'(r);
                    end
                end
            end
            if (i == 300) begin
                v.wv = 1'b1;
                v.wd = 4'd15;
            end
            apply(v); #1;
            n_checks++;
            if (bus.stall !== m_stall(v) || bus.issue_accept !== m_accept(v)) begin
                n_fail++; $display("FAIL random stall/accept cyc %0d got %b/%b exp %b/%b", i,
                    bus.stall, bus.issue_accept, m_stall(v), m_accept(v));
            end
            m_commit(v);
            @(posedge clk); #1;
            n_checks++;
            if (bus.busy_mask !== m_mask() || bus.pending_total !== m_total() || bus.sb_err !== m_err) begin
                n_fail++; $display("FAIL random state cyc %0d got %h/%0d/%b exp %h/%0d/%b", i,
                    bus.busy_mask, bus.pending_total, bus.sb_err, m_mask(), m_total(), m_err);
            end
        end
    endtask

    initial begin
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #1;
        test_reset();
        test_raw_hazard();
        test_full();
        test_two_src();
        test_flush();
        test_underflow_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
